// File: rtl/router_pkg.sv
// ----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the router FIFO slice.
//   DEFAULT_DEPTH / DEFAULT_WIDTH : default FIFO geometry
//   LEN_MSB..LEN_LSB              : payload length field inside a header byte
//   ADDR_MSB..ADDR_LSB            : destination address field inside a header byte
//   pkt_cnt_t                     : packet byte counter (payload + parity)
//   ptr_width()                   : pointer width (index bits plus one wrap bit)
// ----------------------------------------------------------------------------
package router_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_WIDTH = 8;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;

    localparam int PKT_CNT_W = 7;
    typedef logic [PKT_CNT_W-1:0] pkt_cnt_t;

    // The extra top bit lets full and empty be told apart when indices match.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// ----------------------------------------------------------------------------
// router_fifo_mem
// Storage array for the router FIFO: one write port and one synchronous read
// port whose output register can be cleared synchronously.
//   clk   : clock, rising edge
//   we    : write strobe        waddr : write index   wdata : {marker, byte}
//   re    : read strobe         raddr : read index
//   clr   : clear the read data register (takes priority over re)
//   rdata : registered read data {marker, byte}
// ----------------------------------------------------------------------------
module router_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH:0]    wdata,
    input  logic              re,
    input  logic              clr,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH:0]    rdata
);

    logic [WIDTH:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/router_fifo.sv
// ----------------------------------------------------------------------------
// router_fifo
// Per-destination FIFO of the packet router. Each entry holds a byte plus a
// header marker; a packet counter tracks the remaining payload+parity bytes so
// the output can return to 0 once a packet has been fully read.
//   clk        : clock, rising edge
//   resetn     : synchronous active-low reset
//   soft_reset : synchronous flush (time-out), active-high
//   write_enb  : write request          read_enb : read request
//   lfd_state  : current write byte is a packet header
//   data_in    : byte to store          data_out : registered read data
//   full       : DEPTH entries occupied empty    : no entries occupied
//   fifo_err   : sticky overflow/underflow flag, present only when the
//                ROUTER_FIFO_ERR_EN macro is defined
// ----------------------------------------------------------------------------
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
`ifdef ROUTER_FIFO_ERR_EN
    ,
    output logic             fifo_err
`endif
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH:0]   rd_word;
    pkt_cnt_t         count;
    pkt_cnt_t         count_eff;
    logic             pending;
    logic             clearing;
    logic             do_write;
    logic             do_read;
    logic             mem_clr;

    assign clearing = !resetn || soft_reset;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                      (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
    assign do_write = write_enb && !full && !clearing;
    assign do_read  = read_enb && !empty && !clearing;
    assign data_out = rd_word[WIDTH-1:0];

    // The word read on the previous edge only becomes visible in rd_word one
    // cycle later, so the counter is brought up to date here from that word.
    // count_eff is therefore the packet count after every read so far.
    always_comb begin
        count_eff = count;
        if (pending) begin
            if (rd_word[WIDTH]) begin
                count_eff = pkt_cnt_t'(rd_word[LEN_MSB:LEN_LSB]) + 1'b1;
            end else if (count != '0) begin
                count_eff = count - 1'b1;
            end
        end
    end

    // Once the packet is finished and nothing is being read, drop the output
    // back to 0 so the destination sees an idle bus.
    assign mem_clr = clearing || (!do_read && (count_eff == '0));

    // Pointers and counter; both resets flush everything except storage.
    always_ff @(posedge clk) begin
        if (clearing) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_eff;
            pending <= do_read;
        end
    end

`ifdef ROUTER_FIFO_ERR_EN
    // Sticky flag for any write into a full FIFO or read from an empty one.
    always_ff @(posedge clk) begin
        if (clearing) begin
            fifo_err <= 1'b0;
        end else if ((write_enb && full) || (read_enb && empty)) begin
            fifo_err <= 1'b1;
        end
    end
`endif

    router_fifo_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (do_write),
        .waddr (wr_ptr[IDX_W-1:0]),
        .wdata ({lfd_state, data_in}),
        .re    (do_read),
        .clr   (mem_clr),
        .raddr (rd_ptr[IDX_W-1:0]),
        .rdata (rd_word)
    );

endmodule

// File: tb/tb_router_fifo.sv
// ----------------------------------------------------------------------------
// tb_router_fifo
// Self-checking bench for router_fifo. A queue-based reference model follows
// the FIFO rules (occupancy, packet counter, idle clearing) cycle by cycle.
// The fifo_err checks are included when ROUTER_FIFO_ERR_EN is defined.
// ----------------------------------------------------------------------------
module tb_router_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             soft_reset = 1'b0;
    logic             write_enb = 1'b0;
    logic             read_enb = 1'b0;
    logic             lfd_state = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
`ifdef ROUTER_FIFO_ERR_EN
    logic             fifo_err;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [WIDTH:0]   mq[$];
    int               m_cnt = 0;
    logic [WIDTH-1:0] m_dout = '0;
    logic             m_err = 1'b0;

    always #5 clk = ~clk;

    router_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
`ifdef ROUTER_FIFO_ERR_EN
        ,
        .fifo_err   (fifo_err)
`endif
    );

    // Drive one cycle of inputs, clock it, update the model, settle.
    task automatic step(input logic we, input logic re, input logic lfd,
                        input logic [WIDTH-1:0] din, input logic sr,
                        input logic rn);
        logic           wr_ok;
        logic           rd_ok;
        logic [WIDTH:0] w;
        @(negedge clk);
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = din;
        soft_reset = sr;
        resetn     = rn;
        @(posedge clk);
        if (!rn || sr) begin
            mq.delete();
            m_cnt  = 0;
            m_dout = '0;
            m_err  = 1'b0;
        end else begin
            wr_ok = we && (mq.size() < DEPTH);
            rd_ok = re && (mq.size() > 0);
            if ((we && !wr_ok) || (re && !rd_ok)) m_err = 1'b1;
            if (rd_ok) begin
                w = mq.pop_front();
                m_dout = w[WIDTH-1:0];
                if (w[WIDTH]) m_cnt = int'(w[7:2]) + 1;
                else if (m_cnt > 0) m_cnt = m_cnt - 1;
            end else if (m_cnt == 0) begin
                m_dout = '0;
            end
            if (wr_ok) mq.push_back({lfd, din});
        end
        #1;
    endtask

    task automatic reset_dut();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0);
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_empty: got %b expected 1", empty);
        end
        checks++;
        if (full !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_full: got %b expected 0", full);
        end
        checks++;
        if (data_out !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_dout: got %h expected 00", data_out);
        end
`ifdef ROUTER_FIFO_ERR_EN
        checks++;
        if (fifo_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_err: got %b expected 0", fifo_err);
        end
`endif
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_packet();
        logic [WIDTH-1:0] pkt[5];
        reset_dut();
        pkt[0] = 8'h0D;
        for (int i = 1; i < 5; i++) pkt[i] = 8'($urandom_range(1, 255));
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, (i == 0), pkt[i], 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
            checks++;
            if (data_out !== pkt[i] || data_out !== m_dout) begin
                failures++;
                $display("[TB] FAIL packet_byte%0d: got %h expected %h", i, data_out, pkt[i]);
            end
            // Mid-packet pause: the counter is still non-zero, output must hold
            if (i == 1) begin
                step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
                checks++;
                if (data_out !== pkt[1]) begin
                    failures++;
                    $display("[TB] FAIL packet_hold: got %h expected %h", data_out, pkt[1]);
                end
            end
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (data_out !== 8'h00) begin
            failures++;
            $display("[TB] FAIL packet_idle: got %h expected 00", data_out);
        end
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("[TB] FAIL packet_empty: got %b expected 1", empty);
        end
    endtask

    task automatic test_full();
        logic [WIDTH-1:0] bytes[DEPTH];
        reset_dut();
        for (int i = 0; i < DEPTH; i++) begin
            bytes[i] = 8'($urandom_range(0, 255));
            step(1'b1, 1'b0, 1'b0, bytes[i], 1'b0, 1'b1);
        end
        checks++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_flag: got full=%b empty=%b expected full=1 empty=0", full, empty);
        end
        step(1'b1, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1);
`ifdef ROUTER_FIFO_ERR_EN
        checks++;
        if (fifo_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overflow_err: got %b expected 1", fifo_err);
        end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
            checks++;
            if (data_out !== bytes[i]) begin
                failures++;
                $display("[TB] FAIL full_read%0d: got %h expected %h", i, data_out, bytes[i]);
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_drained: got %b expected 1", empty);
        end
    endtask

    task automatic test_full_rw();
        logic [WIDTH-1:0] first;
        reset_dut();
        first = 8'($urandom_range(1, 255));
        step(1'b1, 1'b0, 1'b0, first, 1'b0, 1'b1);
        for (int i = 1; i < DEPTH; i++)
            step(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
        checks++;
        if (data_out !== first) begin
            failures++;
            $display("[TB] FAIL full_rw_dout: got %h expected %h", data_out, first);
        end
        checks++;
        if (full !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_rw_full: got %b expected 0", full);
        end
        for (int i = 1; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
            checks++;
            if (data_out !== m_dout) begin
                failures++;
                $display("[TB] FAIL full_rw_drain%0d: got %h expected %h", i, data_out, m_dout);
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_rw_dropped: got empty=%b expected 1", empty);
        end
    endtask

    task automatic test_empty_rw();
        reset_dut();
        // A long header keeps the counter busy so data_out is not auto-cleared
        step(1'b1, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1);
        checks++;
        if (empty !== 1'b0) begin
            failures++;
            $display("[TB] FAIL empty_rw_empty: got %b expected 0", empty);
        end
        checks++;
        if (data_out !== 8'hF0) begin
            failures++;
            $display("[TB] FAIL empty_rw_hold: got %h expected f0", data_out);
        end
`ifdef ROUTER_FIFO_ERR_EN
        checks++;
        if (fifo_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL underflow_err: got %b expected 1", fifo_err);
        end
`endif
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (data_out !== 8'h55) begin
            failures++;
            $display("[TB] FAIL empty_rw_read: got %h expected 55", data_out);
        end
    endtask

    task automatic test_soft_reset();
        reset_dut();
        step(1'b1, 1'b0, 1'b1, 8'hFC, 1'b0, 1'b1);
        for (int i = 1; i < 8; i++)
            step(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
`ifdef ROUTER_FIFO_ERR_EN
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
        checks++;
        if (fifo_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sr_pre_err: got %b expected 1", fifo_err);
        end
`endif
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (data_out !== 8'hFC || empty !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sr_pre_state: got dout=%h empty=%b expected fc 0", data_out, empty);
        end
        step(1'b1, 1'b1, 1'b0, 8'h99, 1'b1, 1'b1);
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sr_flags: got empty=%b full=%b expected 1 0", empty, full);
        end
        checks++;
        if (data_out !== 8'h00) begin
            failures++;
            $display("[TB] FAIL sr_dout: got %h expected 00", data_out);
        end
`ifdef ROUTER_FIFO_ERR_EN
        checks++;
        if (fifo_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sr_err: got %b expected 0", fifo_err);
        end
`endif
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sr_write_ignored: got empty=%b expected 1", empty);
        end
    endtask

    task automatic test_wrap();
        reset_dut();
        step(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
            checks++;
            if (data_out !== m_dout || full !== 1'b0 || empty !== 1'b0) begin
                failures++;
                $display("[TB] FAIL wrap_pair%0d: got dout=%h full=%b empty=%b expected %h 0 0",
                         i, data_out, full, empty, m_dout);
            end
        end
    endtask

    task automatic test_random();
        logic we;
        logic re;
        logic lfd;
        reset_dut();
        for (int i = 0; i < 300; i++) begin
            we  = ($urandom_range(0, 99) < 55);
            re  = ($urandom_range(0, 99) < 45);
            lfd = ($urandom_range(0, 99) < 10);
            step(we, re, lfd, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
            checks++;
            if (data_out !== m_dout || full !== (mq.size() == DEPTH) ||
                empty !== (mq.size() == 0)) begin
                failures++;
                $display("[TB] FAIL random%0d: got dout=%h full=%b empty=%b expected %h %b %b",
                         i, data_out, full, empty, m_dout, (mq.size() == DEPTH), (mq.size() == 0));
            end
`ifdef ROUTER_FIFO_ERR_EN
            checks++;
            if (fifo_err !== m_err) begin
                failures++;
                $display("[TB] FAIL random_err%0d: got %b expected %b", i, fifo_err, m_err);
            end
`endif
        end
    endtask

    initial begin
        $display("[TB] router_fifo bench start");
        test_reset();
        test_packet();
        test_full();
        test_full_rw();
        test_empty_rw();
        test_soft_reset();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
